// File: rtl/our_axi_sram_bridge.sv
// AXI4 slave bridging one burst at a time onto an internal single-port SRAM (FIXED/INCR/WRAP).
// Latency: reads take 3 cycles per beat (issue, wait, respond); write beats hit the SRAM in the W handshake cycle.
// Backpressure: AR/AW are held by the master until granted; R and B payloads stay stable until rready/bready.
module our_axi_sram_bridge #(
  parameter int DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int ID_WIDTH = 8,
  parameter int MEM_WORDS = 2**21,
  localparam int SRAM_ADDR_WIDTH = $clog2(MEM_WORDS),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       pll_core_cpuclk,
  input  logic                       pad_cpu_rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  araddr_s0,
  input  logic [1:0]                 arburst_s0,
  input  logic [ID_WIDTH-1:0]        arid_s0,
  input  logic [7:0]                 arlen_s0,
  input  logic [2:0]                 arsize_s0,
  input  logic                       arvalid_s0,
  output logic                       arready_s0,
  input  logic [AXI_ADDR_WIDTH-1:0]  awaddr_s0,
  input  logic [1:0]                 awburst_s0,
  input  logic [ID_WIDTH-1:0]        awid_s0,
  input  logic [7:0]                 awlen_s0,
  input  logic [2:0]                 awsize_s0,
  input  logic                       awvalid_s0,
  output logic                       awready_s0,
  input  logic [DATA_WIDTH-1:0]      wdata_s0,
  input  logic [STRB_WIDTH-1:0]      wstrb_s0,
  input  logic                       wlast_s0,
  input  logic                       wvalid_s0,
  output logic                       wready_s0,
  output logic [ID_WIDTH-1:0]        bid_s0,
  output logic [1:0]                 bresp_s0,
  output logic                       bvalid_s0,
  input  logic                       bready_s0,
  output logic [DATA_WIDTH-1:0]      rdata_s0,
  output logic [ID_WIDTH-1:0]        rid_s0,
  output logic [1:0]                 rresp_s0,
  output logic                       rlast_s0,
  output logic                       rvalid_s0,
  input  logic                       rready_s0,
  output logic                       mem_req_o,
  output logic [SRAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  output logic [DATA_WIDTH-1:0]      mem_strb_o,
  output logic                       mem_we_o,
  output logic [DATA_WIDTH-1:0]      mem_rdata_o
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int LB = $clog2(STRB_WIDTH);
  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

  state_t                state;
  logic                  prio_rd;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [AW-1:0]         addr_q;
  logic                  burst_err_q;
  logic                  wr_err_q;

  logic [DATA_WIDTH-1:0] sram [MEM_WORDS];
  logic [DATA_WIDTH-1:0] sram_q;

  logic                  grant_rd, grant_wr, g_err, g_wrap_len_ok;
  logic [AW-1:0]         g_addr, g_inc, g_aligned;
  logic [1:0]            g_burst;
  logic [ID_WIDTH-1:0]   g_id;
  logic [7:0]            g_len;
  logic [2:0]            g_size;
  logic [AW-1:0]         inc, wmask, next_addr, word_idx;
  logic                  beat_err, acc_err, last_beat, wbeat, wr_err_next;

  // Arbitration and payload selection for the address channel being granted from IDLE.
  always_comb begin
    grant_rd      = arvalid_s0 && (!awvalid_s0 || prio_rd);
    grant_wr      = awvalid_s0 && !grant_rd;
    g_addr        = grant_rd ? araddr_s0  : awaddr_s0;
    g_burst       = grant_rd ? arburst_s0 : awburst_s0;
    g_id          = grant_rd ? arid_s0    : awid_s0;
    g_len         = grant_rd ? arlen_s0   : awlen_s0;
    g_size        = grant_rd ? arsize_s0  : awsize_s0;
    g_inc         = AW'(1) << g_size;
    g_aligned     = g_addr & ~(g_inc - AW'(1));
    g_wrap_len_ok = (g_len == 8'd1) || (g_len == 8'd3) || (g_len == 8'd7) || (g_len == 8'd15);
    g_err         = (g_size > 3'(LB)) || (g_burst == 2'b11) || ((g_burst == 2'b10) && !g_wrap_len_ok);
  end

  // Current-beat address, next-beat address and per-beat error decode.
  always_comb begin
    inc   = AW'(1) << size_q;
    wmask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wmask) | ((addr_q + inc) & wmask);
      default: next_addr = addr_q + inc;
    endcase
    word_idx    = addr_q >> LB;
    beat_err    = word_idx >= MEM_LIMIT;
    acc_err     = burst_err_q || beat_err;
    last_beat   = beat_q == len_q;
    wbeat       = (state == WR_DATA) && wvalid_s0 && wready_s0;
    wr_err_next = wr_err_q || beat_err || (wlast_s0 != last_beat);
  end

  // SRAM port drive; reset kills any access in the same cycle so an aborted burst never touches memory.
  always_comb begin
    mem_req_o   = !pad_cpu_rst && !acc_err && ((state == RD_ISSUE) || wbeat);
    mem_we_o    = !pad_cpu_rst && !acc_err && wbeat;
    mem_addr_o  = word_idx[SRAM_ADDR_WIDTH-1:0];
    mem_wdata_o = wdata_s0;
    mem_strb_o  = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      mem_strb_o[i*8 +: 8] = {8{wstrb_s0[i]}};
    end
  end

  assign mem_rdata_o = sram_q;
  assign bid_s0      = id_q;
  assign rid_s0      = id_q;

  // Backing store: bit-masked write, registered read output; contents are never reset.
  always_ff @(posedge pll_core_cpuclk) begin
    if (mem_we_o) begin
      sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_strb_o) | (mem_wdata_o & mem_strb_o);
    end else if (mem_req_o) begin
      sram_q <= sram[mem_addr_o];
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state       <= IDLE;
      prio_rd     <= 1'b1;
      id_q        <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      burst_err_q <= 1'b0;
      wr_err_q    <= 1'b0;
      arready_s0  <= 1'b0;
      awready_s0  <= 1'b0;
      wready_s0   <= 1'b0;
      bvalid_s0   <= 1'b0;
      bresp_s0    <= 2'b00;
      rvalid_s0   <= 1'b0;
      rdata_s0    <= '0;
      rresp_s0    <= 2'b00;
      rlast_s0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            // Priority only moves when both channels competed, so a lone request never steals the other side's turn.
            if (arvalid_s0 && awvalid_s0) prio_rd <= !grant_rd;
            id_q        <= g_id;
            len_q       <= g_len;
            size_q      <= g_size;
            burst_q     <= g_burst;
            addr_q      <= g_aligned;
            beat_q      <= '0;
            burst_err_q <= g_err;
            wr_err_q    <= g_err;
            if (grant_rd) begin
              arready_s0 <= 1'b1;
              state      <= RD_ISSUE;
            end else begin
              awready_s0 <= 1'b1;
              wready_s0  <= 1'b1;
              state      <= WR_DATA;
            end
          end
        end
        RD_ISSUE: begin
          arready_s0 <= 1'b0;
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          rvalid_s0 <= 1'b1;
          rdata_s0  <= acc_err ? '0 : sram_q;
          rresp_s0  <= acc_err ? 2'b10 : 2'b00;
          rlast_s0  <= last_beat;
          state     <= RD_RESP;
        end
        RD_RESP: begin
          if (rready_s0) begin
            rvalid_s0 <= 1'b0;
            rlast_s0  <= 1'b0;
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr;
              state  <= RD_ISSUE;
            end
          end
        end
        WR_DATA: begin
          awready_s0 <= 1'b0;
          if (wbeat) begin
            if (last_beat) begin
              wready_s0 <= 1'b0;
              bvalid_s0 <= 1'b1;
              bresp_s0  <= wr_err_next ? 2'b10 : 2'b00;
              state     <= WR_RESP;
            end else begin
              wr_err_q <= wr_err_next;
              beat_q   <= beat_q + 8'd1;
              addr_q   <= next_addr;
            end
          end
        end
        WR_RESP: begin
          if (bready_s0) begin
            bvalid_s0 <= 1'b0;
            bresp_s0  <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_our_axi_sram_bridge.sv
// Directed bench for our_axi_sram_bridge with a reference memory and scoreboard queues.
// R beats, B responses and SRAM port activity are predicted when stimulus is issued.
// Predictions are popped and compared as the DUT produces each output.
module tb_our_axi_sram_bridge;
  localparam int DW = 128;
  localparam int AW = 40;
  localparam int IW = 8;
  localparam int MW = 64;
  localparam int SAW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] araddr, awaddr;
  logic [1:0] arburst, awburst, bresp, rresp;
  logic [IW-1:0] arid, awid, bid, rid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata, mem_wdata, mem_strb, mem_rdata;
  logic [15:0] wstrb;
  logic mem_req, mem_we;
  logic [SAW-1:0] mem_addr;

  our_axi_sram_bridge #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS(MW)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .araddr_s0(araddr), .arburst_s0(arburst), .arid_s0(arid), .arlen_s0(arlen), .arsize_s0(arsize),
    .arvalid_s0(arvalid), .arready_s0(arready),
    .awaddr_s0(awaddr), .awburst_s0(awburst), .awid_s0(awid), .awlen_s0(awlen), .awsize_s0(awsize),
    .awvalid_s0(awvalid), .awready_s0(awready),
    .wdata_s0(wdata), .wstrb_s0(wstrb), .wlast_s0(wlast), .wvalid_s0(wvalid), .wready_s0(wready),
    .bid_s0(bid), .bresp_s0(bresp), .bvalid_s0(bvalid), .bready_s0(bready),
    .rdata_s0(rdata), .rid_s0(rid), .rresp_s0(rresp), .rlast_s0(rlast), .rvalid_s0(rvalid), .rready_s0(rready),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_we_o(mem_we), .mem_rdata_o(mem_rdata)
  );

  typedef struct {logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IW-1:0] id;} rexp_t;
  typedef struct {int word; logic [DW-1:0] strb;} wev_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int ar_cyc, aw_cyc;
  logic [DW-1:0] ref_mem [MW];
  rexp_t exp_r[$];
  int exp_rd[$], obs_rd[$];
  wev_t exp_wr[$], obs_wr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every SRAM access the DUT makes.
  always @(posedge clk) begin
    wev_t ev;
    if (mem_req) begin
      if (mem_we) begin
        ev.word = int'(mem_addr);
        ev.strb = mem_strb;
        obs_wr.push_back(ev);
      end else begin
        obs_rd.push_back(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expand(input logic [15:0] s);
    logic [DW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic flush_mem(input string tag);
    chk({tag, "_nrd"}, obs_rd.size(), exp_rd.size());
    chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    while (exp_rd.size() > 0 && obs_rd.size() > 0) chk({tag, "_rdword"}, obs_rd.pop_front(), exp_rd.pop_front());
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wev_t o, e;
      o = obs_wr.pop_front();
      e = exp_wr.pop_front();
      chk({tag, "_wrword"}, o.word, e.word);
      chk({tag, "_wrstrb"}, o.strb, e.strb);
    end
    obs_rd.delete(); exp_rd.delete(); obs_wr.delete(); exp_wr.delete();
  endtask

  task automatic recv_r(input string tag);
    rexp_t e;
    for (int n = 0; n < 100 && !rvalid; n++) begin @(posedge clk); #1; end
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    if (!rvalid) return;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    e = exp_r.pop_front();
    chk({tag, "_rdata"}, rdata, e.data);
    chk({tag, "_rresp"}, rresp, e.resp);
    chk({tag, "_rlast"}, rlast, e.last);
    chk({tag, "_rid"}, rid, e.id);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [1:0] bu, input logic [7:0] l,
                         input logic [2:0] sz, input logic [IW-1:0] id, input string tag);
    logic hs, ok;
    ok = 1'b0;
    araddr = a; arburst = bu; arlen = l; arsize = sz; arid = id; arvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    ar_cyc = cyc;
    arvalid = 1'b0;
    chk({tag, "_arhs"}, ok, 1'b1);
  endtask

  // words: expected SRAM word per beat, -1 for an SLVERR beat.
  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] bu, input logic [7:0] l,
                         input logic [2:0] sz, input logic [IW-1:0] id, input int words[$], input string tag);
    rexp_t e;
    foreach (words[i]) begin
      e.data = (words[i] < 0) ? '0 : ref_mem[words[i]];
      e.resp = (words[i] < 0) ? 2'b10 : 2'b00;
      e.last = (i == words.size() - 1);
      e.id   = id;
      exp_r.push_back(e);
      if (words[i] >= 0) exp_rd.push_back(words[i]);
    end
    send_ar(a, bu, l, sz, id, tag);
    foreach (words[i]) recv_r(tag);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] bu, input logic [7:0] l,
                          input logic [2:0] sz, input logic [IW-1:0] id, input logic [DW-1:0] datas[$],
                          input logic [15:0] strbs[$], input int words[$], input int wlast_pos,
                          input logic [1:0] bresp_exp, input string tag);
    logic hs, ok;
    wev_t ev;
    foreach (words[i]) begin
      if (words[i] >= 0) begin
        ev.word = words[i];
        ev.strb = expand(strbs[i]);
        exp_wr.push_back(ev);
        ref_mem[words[i]] = (ref_mem[words[i]] & ~ev.strb) | (datas[i] & ev.strb);
      end
    end
    ok = 1'b0;
    awaddr = a; awburst = bu; awlen = l; awsize = sz; awid = id; awvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      hs = awready;
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    aw_cyc = cyc;
    awvalid = 1'b0;
    chk({tag, "_awhs"}, ok, 1'b1);
    foreach (words[b]) begin
      wdata = datas[b]; wstrb = strbs[b]; wlast = (b == wlast_pos); wvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        hs = wready;
        @(posedge clk); #1;
        if (hs) begin ok = 1'b1; break; end
      end
      chk({tag, "_whs"}, ok, 1'b1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int n = 0; n < 50 && !bvalid; n++) begin @(posedge clk); #1; end
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, bresp_exp);
    chk({tag, "_bid"}, bid, id);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w[$], w2[$];
    logic [DW-1:0] d[$], d2[$];
    logic [15:0] s[$], s2[$];
    rexp_t e;

    rst = 1'b1;
    araddr = '0; arburst = '0; arid = '0; arlen = '0; arsize = '0; arvalid = 1'b0;
    awaddr = '0; awburst = '0; awid = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rdata", rdata, '0);
    chk("rst_rlast", rlast, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload words 0..3, 4 (0xA5 pattern) and 63.
    w = '{0, 1, 2, 3}; s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    d.delete(); repeat (4) d.push_back(rnd128());
    do_write(40'h0, 2'b01, 8'd3, 3'd4, 8'h11, d, s, w, 3, 2'b00, "pre0"); flush_mem("pre0");
    w = '{4}; s = '{16'hFFFF}; d = '{{16{8'hA5}}};
    do_write(40'h40, 2'b01, 8'd0, 3'd4, 8'h12, d, s, w, 0, 2'b00, "pre4"); flush_mem("pre4");
    w = '{63}; d = '{rnd128()};
    do_write(40'h3F0, 2'b01, 8'd0, 3'd4, 8'h13, d, s, w, 0, 2'b00, "pre63"); flush_mem("pre63");

    w = '{4};
    do_read(40'h40, 2'b01, 8'd0, 3'd4, 8'h21, w, "rd_single"); flush_mem("rd_single");

    // Full write then partial-strobe INCR write at 0x100, read back the merged words.
    w = '{16, 17, 18, 19}; s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    d.delete(); repeat (4) d.push_back(rnd128());
    do_write(40'h100, 2'b01, 8'd3, 3'd4, 8'h31, d, s, w, 3, 2'b00, "wr_full"); flush_mem("wr_full");
    s = '{16'hFFFF, 16'h00FF, 16'hFF00, 16'h0001};
    d.delete(); repeat (4) d.push_back(rnd128());
    do_write(40'h100, 2'b01, 8'd3, 3'd4, 8'h32, d, s, w, 3, 2'b00, "wr_strb"); flush_mem("wr_strb");
    do_read(40'h100, 2'b01, 8'd3, 3'd4, 8'h33, w, "rd_merge"); flush_mem("rd_merge");

    w = '{3, 0, 1, 2};
    do_read(40'h30, 2'b10, 8'd3, 3'd4, 8'h41, w, "rd_wrap"); flush_mem("rd_wrap");
    w = '{63, -1};
    do_read(40'h3F0, 2'b01, 8'd1, 3'd4, 8'h42, w, "rd_edge"); flush_mem("rd_edge");
    w = '{-1, -1, -1};
    do_read(40'h0, 2'b10, 8'd2, 3'd4, 8'h43, w, "rd_wrap_len2"); flush_mem("rd_wrap_len2");
    w = '{-1};
    do_read(40'h40, 2'b01, 8'd0, 3'd5, 8'h44, w, "rd_size5"); flush_mem("rd_size5");
    w = '{1, 1};
    do_read(40'h10, 2'b00, 8'd1, 3'd4, 8'h45, w, "rd_fixed"); flush_mem("rd_fixed");

    // Early wlast: all four beats still written, response SLVERR.
    w = '{32, 33, 34, 35}; s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    d.delete(); repeat (4) d.push_back(rnd128());
    do_write(40'h200, 2'b01, 8'd3, 3'd4, 8'h51, d, s, w, 1, 2'b10, "wr_wlast"); flush_mem("wr_wlast");
    do_read(40'h200, 2'b01, 8'd3, 3'd4, 8'h52, w, "rd_wlast"); flush_mem("rd_wlast");
    w = '{63, -1}; s = '{16'hFFFF, 16'hFFFF};
    d.delete(); repeat (2) d.push_back(rnd128());
    do_write(40'h3F0, 2'b01, 8'd1, 3'd4, 8'h53, d, s, w, 1, 2'b10, "wr_edge"); flush_mem("wr_edge");

    // Reset while beat 2 of a 4-beat read is being issued.
    for (int i = 0; i < 2; i++) begin
      e.data = ref_mem[i]; e.resp = 2'b00; e.last = 1'b0; e.id = 8'h61;
      exp_r.push_back(e);
      exp_rd.push_back(i);
    end
    send_ar(40'h0, 2'b01, 8'd3, 3'd4, 8'h61, "abort");
    recv_r("abort");
    recv_r("abort");
    rst = 1'b1;
    #0;
    chk("abort_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("abort_rvalid", rvalid, 1'b0);
    chk("abort_rdata", rdata, '0);
    chk("abort_rlast", rlast, 1'b0);
    chk("abort_arready", arready, 1'b0);
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_quiet", rvalid, 1'b0);
    exp_r.delete();
    flush_mem("abort");

    // Simultaneous AR/AW right after reset: read wins, then the next contested pair goes to write.
    w = '{4}; w2 = '{5}; s2 = '{16'hFFFF}; d2 = '{rnd128()};
    fork
      do_read(40'h40, 2'b01, 8'd0, 3'd4, 8'h71, w, "arb1r");
      do_write(40'h50, 2'b01, 8'd0, 3'd4, 8'h72, d2, s2, w2, 0, 2'b00, "arb1w");
    join
    chk("arb1_read_first", ar_cyc < aw_cyc, 1'b1);
    flush_mem("arb1");
    d2 = '{rnd128()};
    fork
      do_read(40'h40, 2'b01, 8'd0, 3'd4, 8'h73, w, "arb2r");
      do_write(40'h50, 2'b01, 8'd0, 3'd4, 8'h74, d2, s2, w2, 0, 2'b00, "arb2w");
    join
    chk("arb2_write_first", aw_cyc < ar_cyc, 1'b1);
    flush_mem("arb2");
    w = '{5};
    do_read(40'h50, 2'b01, 8'd0, 3'd4, 8'h75, w, "rd_arbw"); flush_mem("rd_arbw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
